// File: rtl/demux_2ch.sv
// -----------------------------------------------------------------------------
// demux_2ch -- registered 1-to-2 byte demultiplexer.
//
// Steers one valid/ready byte stream onto two output channels, A and B. The
// target is either picked by `sel` or, with `alt_en` high, alternates
// A,B,A,B... per accepted byte, which de-interleaves a stream produced by the
// matching 2:1 selector. Each channel has a one-entry output register with
// valid/ready handshake and a wrapping byte counter.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_data/in_valid    upstream byte and its valid
//   in_ready            combinational: target channel can take a byte now
//   sel                 target when alt_en=0 (0 = A, 1 = B)
//   alt_en              alternate targets per accepted byte, sel ignored
//   cnt_clr             synchronous clear of both counters (wins over +1)
//   a_data/a_valid      channel A output register and its valid
//   a_ready             downstream consumes channel A
//   b_data/b_valid      channel B output register and its valid
//   b_ready             downstream consumes channel B
//   a_count/b_count     bytes accepted into each channel, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module demux_2ch #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic             alt_en,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // State registers and their next-state values
  logic [WIDTH-1:0] a_data_q,  a_data_d;
  logic             a_valid_q, a_valid_d;
  logic [WIDTH-1:0] b_data_q,  b_data_d;
  logic             b_valid_q, b_valid_d;
  logic [CNT_W-1:0] a_cnt_q,   a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q,   b_cnt_d;
  logic             alt_ptr_q, alt_ptr_d;

  // Handshake decode
  logic a_can_load_s;
  logic b_can_load_s;
  logic tgt_s;
  logic accept_s;
  logic load_a_s;
  logic load_b_s;

  // Target selection, ready generation and per-channel load strobes.
  always_comb begin
    // A channel can take a byte when empty or when its held byte leaves now,
    // which is what allows drain and reload in the same cycle.
    a_can_load_s = !a_valid_q || a_ready;
    b_can_load_s = !b_valid_q || b_ready;
    tgt_s        = alt_en ? alt_ptr_q : sel;
    // Gating with rst keeps in_ready low for the whole reset interval.
    if (tgt_s) begin
      in_ready = !rst && b_can_load_s;
    end else begin
      in_ready = !rst && a_can_load_s;
    end
    accept_s = in_valid && in_ready;
    load_a_s = accept_s && !tgt_s;
    load_b_s = accept_s &&  tgt_s;
  end

  // Next state for channel A: output register, valid and byte counter.
  always_comb begin
    a_data_d  = a_data_q;
    a_valid_d = a_valid_q;
    a_cnt_d   = a_cnt_q;
    if (load_a_s) begin
      a_data_d  = in_data;
      a_valid_d = 1'b1;
    end else if (a_ready) begin
      // Drain: data register keeps its last byte, only valid drops.
      a_valid_d = 1'b0;
    end else begin
      a_valid_d = a_valid_q;
    end
    if (cnt_clr) begin
      a_cnt_d = CNT_ZERO;
    end else if (load_a_s) begin
      a_cnt_d = a_cnt_q + CNT_ONE;
    end else begin
      a_cnt_d = a_cnt_q;
    end
  end

  // Next state for channel B: output register, valid and byte counter.
  always_comb begin
    b_data_d  = b_data_q;
    b_valid_d = b_valid_q;
    b_cnt_d   = b_cnt_q;
    if (load_b_s) begin
      b_data_d  = in_data;
      b_valid_d = 1'b1;
    end else if (b_ready) begin
      b_valid_d = 1'b0;
    end else begin
      b_valid_d = b_valid_q;
    end
    if (cnt_clr) begin
      b_cnt_d = CNT_ZERO;
    end else if (load_b_s) begin
      b_cnt_d = b_cnt_q + CNT_ONE;
    end else begin
      b_cnt_d = b_cnt_q;
    end
  end

  // Alternation pointer: held at A while alternation is off so that turning
  // it on always starts with channel A; otherwise flips on every accept.
  always_comb begin
    if (!alt_en) begin
      alt_ptr_d = 1'b0;
    end else if (accept_s) begin
      alt_ptr_d = ~alt_ptr_q;
    end else begin
      alt_ptr_d = alt_ptr_q;
    end
  end

  // State update with asynchronous reset; reset discards any held bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_data_q  <= {WIDTH{1'b0}};
      a_valid_q <= 1'b0;
      b_data_q  <= {WIDTH{1'b0}};
      b_valid_q <= 1'b0;
      a_cnt_q   <= CNT_ZERO;
      b_cnt_q   <= CNT_ZERO;
      alt_ptr_q <= 1'b0;
    end else begin
      a_data_q  <= a_data_d;
      a_valid_q <= a_valid_d;
      b_data_q  <= b_data_d;
      b_valid_q <= b_valid_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      alt_ptr_q <= alt_ptr_d;
    end
  end

  // Outputs come straight from the registers.
  assign a_data  = a_data_q;
  assign a_valid = a_valid_q;
  assign b_data  = b_data_q;
  assign b_valid = b_valid_q;
  assign a_count = a_cnt_q;
  assign b_count = b_cnt_q;

  demux_2ch_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .load_a   (load_a_s),
    .load_b   (load_b_s),
    .a_data   (a_data_q),
    .a_valid  (a_valid_q),
    .a_ready  (a_ready),
    .b_data   (b_data_q),
    .b_valid  (b_valid_q),
    .b_ready  (b_ready)
  );

endmodule

// -----------------------------------------------------------------------------
// demux_2ch_chk -- handshake properties of demux_2ch.
//
// Ports: clock/reset, the input byte, the two internal load strobes, and the
// data/valid/ready of each channel. Holds no state of its own.
// -----------------------------------------------------------------------------
module demux_2ch_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] in_data,
  input logic             load_a,
  input logic             load_b,
  input logic [WIDTH-1:0] a_data,
  input logic             a_valid,
  input logic             a_ready,
  input logic [WIDTH-1:0] b_data,
  input logic             b_valid,
  input logic             b_ready
);

  // A stalled channel keeps its byte and valid.
  a_hold_p: assert property (@(posedge clk) disable iff (rst)
    (a_valid && !a_ready) |=> (a_valid && $stable(a_data)));
  b_hold_p: assert property (@(posedge clk) disable iff (rst)
    (b_valid && !b_ready) |=> (b_valid && $stable(b_data)));

  // An accepted byte shows up on its channel in the next cycle.
  a_load_p: assert property (@(posedge clk) disable iff (rst)
    load_a |=> (a_valid && (a_data == $past(in_data))));
  b_load_p: assert property (@(posedge clk) disable iff (rst)
    load_b |=> (b_valid && (b_data == $past(in_data))));

  // Never both channels from one byte.
  one_hot_p: assert property (@(posedge clk) disable iff (rst)
    !(load_a && load_b));

endmodule

// File: tb/tb_demux_2ch.sv
module tb_demux_2ch;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sel;
  logic             alt_en;
  logic             cnt_clr;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  int checks = 0;
  int errors = 0;

  demux_2ch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .alt_en   (alt_en),
    .cnt_clr  (cnt_clr),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       sel;
    logic       alt;
    logic       ar;
    logic       br;
    logic       clr;
    logic       e_ir;
    logic       e_av;
    logic [7:0] e_ad;
    logic       e_bv;
    logic [7:0] e_bd;
    logic [3:0] e_ac;
    logic [3:0] e_bc;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic av, input logic [7:0] ad,
                            input logic bv, input logic [7:0] bd,
                            input logic [3:0] ac, input logic [3:0] bc);
    check({tag, " a_valid"}, {31'd0, a_valid}, {31'd0, av});
    check({tag, " a_data"},  {24'd0, a_data},  {24'd0, ad});
    check({tag, " b_valid"}, {31'd0, b_valid}, {31'd0, bv});
    check({tag, " b_data"},  {24'd0, b_data},  {24'd0, bd});
    check({tag, " a_count"}, {28'd0, a_count}, {28'd0, ac});
    check({tag, " b_count"}, {28'd0, b_count}, {28'd0, bc});
  endtask

  initial begin
    //            iv    d      sel   alt   ar    br    clr   ir    av    ad     bv    bd     ac     bc
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 4'd1, 4'd0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 4'd2, 4'd0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 4'd3, 4'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 8'h00, 4'd3, 4'd0};
    // alternation, both ready
    vecs[4]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 4'd4, 4'd0};
    vecs[5]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 8'h02, 4'd4, 4'd1};
    vecs[6]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 8'h02, 4'd5, 4'd1};
    vecs[7]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 8'h04, 4'd5, 4'd2};
    vecs[8]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 8'h04, 4'd6, 4'd2};
    vecs[9]  = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 8'h06, 4'd6, 4'd3};
    // odd byte leaves pointer at B; dropping alt_en must restart at A
    vecs[10] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 8'h06, 4'd7, 4'd3};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h07, 1'b0, 8'h06, 4'd7, 4'd3};
    vecs[12] = '{1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 8'h06, 4'd8, 4'd3};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 8'h06, 4'd8, 4'd3};
    // backpressure on B, A still usable, then drain+reload of B
    vecs[14] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 8'hAA, 4'd8, 4'd4};
    vecs[15] = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b1, 8'hAA, 4'd8, 4'd4};
    vecs[16] = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hCC, 1'b1, 8'hAA, 4'd9, 4'd4};
    vecs[17] = '{1'b1, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hCC, 1'b1, 8'hBB, 4'd9, 4'd5};
    vecs[18] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hCC, 1'b1, 8'h5A, 4'd9, 4'd6};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hCC, 1'b0, 8'h5A, 4'd9, 4'd6};
    // cnt_clr wins over a same-cycle increment
    vecs[20] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'h5A, 4'd0, 4'd0};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 8'h5A, 4'd0, 4'd0};

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; sel = 1'b0; alt_en = 1'b0;
    cnt_clr = 1'b0; a_ready = 1'b0; b_ready = 1'b0;

    // reset state
    #12;
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check_outs("rst", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'd0);
    #5;
    rst = 1'b0;
    #1;
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      in_valid = vecs[i].iv;  in_data = vecs[i].d;   sel = vecs[i].sel;
      alt_en   = vecs[i].alt; a_ready = vecs[i].ar;  b_ready = vecs[i].br;
      cnt_clr  = vecs[i].clr;
      #1;
      check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
      step();
      check_outs($sformatf("v%0d", i), vecs[i].e_av, vecs[i].e_ad, vecs[i].e_bv,
                 vecs[i].e_bd, vecs[i].e_ac, vecs[i].e_bc);
    end

    // counter wrap: 17 bytes into A from zero
    in_valid = 1'b1; sel = 1'b0; alt_en = 1'b0; a_ready = 1'b1; b_ready = 1'b1; cnt_clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'h40 + 8'(i);
      step();
      if (i == 15) check("wrap a_count at 16", {28'd0, a_count}, 32'd0);
    end
    check("wrap a_count at 17", {28'd0, a_count}, 32'd1);
    check("wrap a_data", {24'd0, a_data}, 32'h50);
    in_valid = 1'b0;
    step();

    // fill both channels with the pointer left on B
    alt_en = 1'b1; in_valid = 1'b1; a_ready = 1'b1; b_ready = 1'b0;
    in_data = 8'h9A; step();
    in_data = 8'h9B; step();
    in_data = 8'h9C; step();
    in_valid = 1'b0; a_ready = 1'b0;
    check("full a_data", {24'd0, a_data}, 32'h9C);
    check("full b_data", {24'd0, b_data}, 32'h9B);
    check("full valids", {30'd0, a_valid, b_valid}, 32'd3);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b1;
    #1;
    check("async in_ready", {31'd0, in_ready}, 32'd0);
    check_outs("async", 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 4'd0);
    step();
    @(negedge clk);
    rst = 1'b0;
    alt_en = 1'b1; in_valid = 1'b1; in_data = 8'h3C; a_ready = 1'b1; b_ready = 1'b1;
    #1;
    check("restart in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_outs("restart", 1'b1, 8'h3C, 1'b0, 8'h00, 4'd1, 4'd0);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
